// File: rtl/acc_feeder_pkg.sv
// acc_feeder_pkg: default widths and FSM state type shared by the acc_feeder slice.
package acc_feeder_pkg;

  localparam int unsigned IN_DATA_WIDTH_DEF = 8;
  localparam int unsigned DWIDTH_DEF        = 16;
  localparam int unsigned AWIDTH_DEF        = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/acc_feeder_if.sv
// acc_feeder_if: BRAM read port plus accumulator-core valid/run link.
//   master (feeder): drives addr_o, ce_o, acc_number_o, acc_valid_o, acc_run_o
//   slave (BRAM/core side): drives q_i, acc_valid_i, acc_result_i
interface acc_feeder_if
  import acc_feeder_pkg::*;
#(
  parameter int unsigned IN_DATA_WIDTH = IN_DATA_WIDTH_DEF,
  parameter int unsigned DWIDTH        = DWIDTH_DEF,
  parameter int unsigned AWIDTH        = AWIDTH_DEF
) ();

  logic [AWIDTH-1:0]        addr_o;
  logic                     ce_o;
  logic [IN_DATA_WIDTH-1:0] q_i;
  logic [IN_DATA_WIDTH-1:0] acc_number_o;
  logic                     acc_valid_o;
  logic                     acc_run_o;
  logic                     acc_valid_i;
  logic [DWIDTH-1:0]        acc_result_i;

  modport master (
    output addr_o, ce_o, acc_number_o, acc_valid_o, acc_run_o,
    input  q_i, acc_valid_i, acc_result_i
  );

  modport slave (
    input  addr_o, ce_o, acc_number_o, acc_valid_o, acc_run_o,
    output q_i, acc_valid_i, acc_result_i
  );

endinterface

// File: rtl/acc_feeder_cnt.sv
// acc_feeder_cnt: clearable up-counter with terminal-count flag.
//   clr_i has priority over inc_i; tc_o is high while cnt_o == last_i.
module acc_feeder_cnt
  import acc_feeder_pkg::*;
#(
  parameter int unsigned WIDTH = AWIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] last_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/acc_feeder.sv
// acc_feeder: reads N operands from a 1-cycle BRAM, streams them to the
// accumulator core and reports (core total at end - core total at start).
//   start_i/num_cnt_i : job request, sampled in IDLE only
//   bus (master)      : BRAM read port and core valid/run link
//   idle_o/running_o  : FSM status; done_o pulses once with result_o
module acc_feeder
  import acc_feeder_pkg::*;
#(
  parameter int unsigned IN_DATA_WIDTH = IN_DATA_WIDTH_DEF,
  parameter int unsigned DWIDTH        = DWIDTH_DEF,
  parameter int unsigned AWIDTH        = AWIDTH_DEF,
  parameter int unsigned CNT_WIDTH     = AWIDTH + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] num_cnt_i,
  acc_feeder_if.master         bus,
  output logic                 idle_o,
  output logic                 running_o,
  output logic                 done_o,
  output logic [DWIDTH-1:0]    result_o
);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] last_q, last_d;
  logic [DWIDTH-1:0] base_q, base_d;
  logic [DWIDTH-1:0] result_q, result_d;
  logic              valid_q, valid_d;

  logic              iss_clr, iss_inc, iss_tc;
  logic              ret_clr, ret_inc, ret_tc;
  logic [AWIDTH-1:0] iss_cnt;
  logic [AWIDTH-1:0] ret_cnt_unused;
  logic              active;

  acc_feeder_cnt #(.WIDTH(AWIDTH)) u_iss_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (iss_clr),
    .inc_i   (iss_inc),
    .last_i  (last_q),
    .cnt_o   (iss_cnt),
    .tc_o    (iss_tc)
  );

  acc_feeder_cnt #(.WIDTH(AWIDTH)) u_ret_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (ret_clr),
    .inc_i   (ret_inc),
    .last_i  (last_q),
    .cnt_o   (ret_cnt_unused),
    .tc_o    (ret_tc)
  );

  assign active = (state_q == ST_RUN) || (state_q == ST_WAIT);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    base_d   = base_q;
    result_d = result_q;
    valid_d  = (state_q == ST_RUN);
    iss_clr  = 1'b0;
    iss_inc  = 1'b0;
    ret_clr  = 1'b0;
    ret_inc  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (num_cnt_i == '0) begin
            result_d = '0;
            state_d  = ST_DONE;
          end else begin
            // N-1 in AWIDTH bits: N = 2^AWIDTH maps to all-ones, the last address.
            last_d  = num_cnt_i[AWIDTH-1:0] - AWIDTH'(1);
            base_d  = bus.acc_result_i;
            iss_clr = 1'b1;
            ret_clr = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Hold the address at N-1 on the final issue rather than wrapping.
        if (iss_tc) begin
          state_d = ST_WAIT;
        end else begin
          iss_inc = 1'b1;
        end
      end
      ST_WAIT: begin
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase

    // Returned ticks close the job; placed last so it overrides RUN->WAIT.
    if (active && bus.acc_valid_i) begin
      ret_inc = 1'b1;
      if (ret_tc) begin
        result_d = bus.acc_result_i - base_q;
        state_d  = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      last_q   <= '0;
      base_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      base_q   <= base_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.ce_o         = (state_q == ST_RUN);
  assign bus.addr_o       = iss_cnt;
  assign bus.acc_valid_o  = valid_q;
  assign bus.acc_number_o = bus.q_i;
  assign bus.acc_run_o    = active;

  assign idle_o    = (state_q == ST_IDLE);
  assign running_o = active;
  assign done_o    = (state_q == ST_DONE);
  assign result_o  = result_q;

endmodule

// File: tb/tb_acc_feeder.sv
module tb_acc_feeder;

  localparam int unsigned IW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 10;
  localparam int unsigned CW = 11;

  logic          clk;
  logic          reset_n;
  logic          start_i;
  logic [CW-1:0] num_cnt_i;
  logic          idle_o;
  logic          running_o;
  logic          done_o;
  logic [DW-1:0] result_o;

  acc_feeder_if #(.IN_DATA_WIDTH(IW), .DWIDTH(DW), .AWIDTH(AW)) bus ();

  acc_feeder #(
    .IN_DATA_WIDTH (IW),
    .DWIDTH        (DW),
    .AWIDTH        (AW),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (start_i),
    .num_cnt_i (num_cnt_i),
    .bus       (bus),
    .idle_o    (idle_o),
    .running_o (running_o),
    .done_o    (done_o),
    .result_o  (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM and accumulator-core models
  logic [IW-1:0] mem [0:(1<<AW)-1];
  logic [IW-1:0] bram_q     = '0;
  logic          core_tick  = 1'b0;
  logic [DW-1:0] core_total = '0;
  logic          spur       = 1'b0;
  logic          preset_req = 1'b0;
  logic [DW-1:0] preset_val = '0;

  always @(posedge clk) begin
    if (bus.ce_o) bram_q <= mem[bus.addr_o];
    core_tick <= bus.acc_valid_o && bus.acc_run_o;
    if (preset_req) core_total <= preset_val;
    else if (bus.acc_valid_o && bus.acc_run_o) core_total <= core_total + DW'(bus.acc_number_o);
  end

  assign bus.q_i          = bram_q;
  assign bus.acc_valid_i  = core_tick | spur;
  assign bus.acc_result_i = core_total;

  // Monitor
  int unsigned   cyc = 0;
  logic [AW-1:0] ce_log[$];
  int unsigned   valid_total = 0;
  int unsigned   done_total  = 0;
  int unsigned   run_viol    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.ce_o) ce_log.push_back(bus.addr_o);
    if (bus.acc_valid_o) valid_total <= valid_total + 1;
    if (done_o) done_total <= done_total + 1;
    if (bus.acc_valid_o && !bus.acc_run_o) run_viol <= run_viol + 1;
  end

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int unsigned n;
    int unsigned mode;      // 0: k+1, 1: constant val, 2: 4+2k
    int unsigned val;
    bit          preset_en;
    logic [15:0] preset;
    logic [15:0] exp_res;
    int unsigned exp_lat;
    bit          start_in_done;
    int unsigned glitch;
  } vec_t;

  vec_t vecs[7];

  task automatic fill(input int unsigned n, input int unsigned mode, input int unsigned val);
    for (int unsigned k = 0; k < n; k++) begin
      case (mode)
        0:       mem[k] = IW'(k + 1);
        1:       mem[k] = IW'(val);
        default: mem[k] = IW'(4 + 2 * k);
      endcase
    end
  endtask

  task automatic preset_core(input logic [DW-1:0] v);
    @(negedge clk);
    preset_val = v;
    preset_req = 1'b1;
    @(negedge clk);
    preset_req = 1'b0;
  endtask

  task automatic run_job(input string tag, input int unsigned n, input logic [DW-1:0] exp_res,
                         input int unsigned exp_lat, input bit start_in_done, input int unsigned glitch);
    int unsigned ce0, v0, d0, s, lat, bad;
    bit found;
    ce0 = ce_log.size();
    v0  = valid_total;
    d0  = done_total;
    @(negedge clk);
    start_i   = 1'b1;
    num_cnt_i = CW'(n);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    s = cyc;
    check({tag, ".running"}, {31'd0, running_o}, {31'd0, (n != 0)});
    found = 1'b0;
    for (int unsigned i = 0; i < exp_lat + 20; i++) begin
      if (done_o) begin
        found = 1'b1;
        break;
      end
      if (glitch != 0 && (cyc - s) == glitch) begin
        start_i   = 1'b1;
        num_cnt_i = CW'(9);
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    lat = cyc - s + 1;
    check({tag, ".done_seen"}, {31'd0, found}, 32'd1);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".result"}, {16'd0, result_o}, {16'd0, exp_res});
    check({tag, ".issues"}, ce_log.size() - ce0, n);
    bad = 0;
    for (int unsigned k = 0; k < n && (ce0 + k) < ce_log.size(); k++)
      if (ce_log[ce0 + k] != AW'(k)) bad++;
    check({tag, ".addr_order_errs"}, bad, 0);
    check({tag, ".valids"}, valid_total - v0, n);
    if (start_in_done) begin
      start_i   = 1'b1;
      num_cnt_i = CW'(3);
    end
    @(negedge clk);
    start_i = 1'b0;
    check({tag, ".done_width"}, {31'd0, done_o}, 32'd0);
    check({tag, ".idle_after"}, {31'd0, idle_o}, 32'd1);
    @(negedge clk);
    check({tag, ".no_restart"}, {31'd0, bus.ce_o}, 32'd0);
    check({tag, ".done_count"}, done_total - d0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, sum;
    logic [DW-1:0] pv;

    vecs[0] = '{4,    0, 0,   1'b1, 16'd0,     16'd10,    7,    1'b0, 0};
    vecs[1] = '{1,    1, 5,   1'b0, 16'd0,     16'd5,     4,    1'b1, 0};
    vecs[2] = '{300,  1, 255, 1'b0, 16'd0,     16'd10964, 303,  1'b0, 0};
    vecs[3] = '{2,    2, 0,   1'b1, 16'd65530, 16'd10,    5,    1'b0, 0};
    vecs[4] = '{0,    0, 0,   1'b0, 16'd0,     16'd0,     1,    1'b0, 0};
    vecs[5] = '{4,    0, 0,   1'b0, 16'd0,     16'd10,    7,    1'b0, 2};
    vecs[6] = '{1024, 1, 1,   1'b0, 16'd0,     16'd1024,  1027, 1'b0, 0};

    reset_n   = 1'b0;
    start_i   = 1'b0;
    num_cnt_i = '0;
    repeat (3) @(negedge clk);
    check("rst.idle",    {31'd0, idle_o},          32'd1);
    check("rst.running", {31'd0, running_o},       32'd0);
    check("rst.done",    {31'd0, done_o},          32'd0);
    check("rst.result",  {16'd0, result_o},        32'd0);
    check("rst.ce",      {31'd0, bus.ce_o},        32'd0);
    check("rst.addr",    {22'd0, bus.addr_o},      32'd0);
    check("rst.valid",   {31'd0, bus.acc_valid_o}, 32'd0);
    check("rst.run",     {31'd0, bus.acc_run_o},   32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int unsigned i = 0; i < 7; i++) begin
      fill(vecs[i].n, vecs[i].mode, vecs[i].val);
      if (vecs[i].preset_en) preset_core(vecs[i].preset);
      run_job($sformatf("vec%0d", i), vecs[i].n, vecs[i].exp_res, vecs[i].exp_lat,
              vecs[i].start_in_done, vecs[i].glitch);
    end

    // Random jobs with spurious idle ticks, checked against the sum of the words read.
    for (int unsigned j = 0; j < 10; j++) begin
      n = $urandom_range(40, 1);
      sum = 0;
      for (int unsigned k = 0; k < n; k++) begin
        mem[k] = IW'($urandom);
        sum += mem[k];
      end
      pv = DW'($urandom);
      preset_core(pv);
      spur = 1'b1;
      repeat ($urandom_range(3, 1)) @(negedge clk);
      spur = 1'b0;
      check($sformatf("rnd%0d.spur_idle", j), {31'd0, idle_o}, 32'd1);
      run_job($sformatf("rnd%0d", j), n, DW'(sum), n + 3, 1'b0, 0);
    end

    // Reset in the middle of an N=8 job.
    fill(8, 0, 0);
    @(negedge clk);
    start_i   = 1'b1;
    num_cnt_i = CW'(8);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check("midrst.ce_before",    {31'd0, bus.ce_o},        32'd1);
    check("midrst.valid_before", {31'd0, bus.acc_valid_o}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst.ce",      {31'd0, bus.ce_o},        32'd0);
    check("midrst.valid",   {31'd0, bus.acc_valid_o}, 32'd0);
    check("midrst.run",     {31'd0, bus.acc_run_o},   32'd0);
    check("midrst.idle",    {31'd0, idle_o},          32'd1);
    check("midrst.running", {31'd0, running_o},       32'd0);
    check("midrst.result",  {16'd0, result_o},        32'd0);
    check("midrst.addr",    {22'd0, bus.addr_o},      32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n = done_total;
    repeat (15) @(negedge clk);
    check("midrst.no_done", done_total - n, 0);
    mem[0] = 8'd77;
    mem[1] = 8'd200;
    run_job("after_rst", 2, 16'd277, 5, 1'b0, 0);

    check("run_covers_valid", run_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
